// File: rtl/memory_stage.sv
// memory_stage: MEM stage of a 5-stage MIPS pipeline.
// Accepts one instruction at a time from EX, runs loads/stores over a
// req/gnt/rvalid data-memory bus and hands the writeback bundle to WB over a
// valid/ready handshake. Back-to-back accepts are possible from OUT.
// Optional feature: define MEM_MISALIGN_TRAP_EN to trap misaligned half/word
// accesses (adds the out_exc output); otherwise low address bits are ignored.
module memory_stage #(
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  resetn,
  // EX side
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [4:0]            in_rd,
  input  logic [31:0]           in_out,
  input  logic [31:0]           in_vt,
  input  logic                  in_mem_read,
  input  logic                  in_mem_write,
  input  logic [1:0]            in_size,
  input  logic                  in_unsigned,
  input  logic                  in_reg_write,
  // data-memory bus
  output logic                  dm_req,
  output logic                  dm_we,
  output logic [ADDR_WIDTH-1:0] dm_addr,
  output logic [3:0]            dm_be,
  output logic [31:0]           dm_wdata,
  input  logic                  dm_gnt,
  input  logic                  dm_rvalid,
  input  logic [31:0]           dm_rdata,
  // WB side
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [4:0]            out_rd,
  output logic [31:0]           out_result,
`ifdef MEM_MISALIGN_TRAP_EN
  output logic                  out_exc,
`endif
  output logic                  out_reg_write
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_OUT
  } state_e;

  state_e      state_q, state_d;
  logic [4:0]  rd_q, rd_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] vt_q, vt_d;
  logic        is_store_q, is_store_d;
  logic [1:0]  size_q, size_d;
  logic        uns_q, uns_d;
  logic        reg_write_q, reg_write_d;
  logic [31:0] result_q, result_d;
  logic        out_regw_q, out_regw_d;
  logic        exc_q, exc_d;

  logic        accept;
  logic        misaligned;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] ld_data;

  assign in_ready = (state_q == S_IDLE) | ((state_q == S_OUT) & out_ready);
  assign accept   = in_valid & in_ready;

`ifdef MEM_MISALIGN_TRAP_EN
  // Half needs a[0]=0, word (size 1x) needs a=00; bytes are always aligned.
  assign misaligned = (in_mem_read | in_mem_write) &
                      ((in_size == 2'b01) ? in_out[0] :
                       in_size[1]         ? (in_out[1:0] != 2'b00) : 1'b0);
`else
  assign misaligned = 1'b0;
`endif

  // Bus outputs come straight from the state/latched fields, so dm_req falls
  // the instant the async reset clears state_q.
  assign dm_req  = (state_q == S_REQ);
  assign dm_we   = (state_q == S_REQ) & is_store_q;
  assign dm_addr = {addr_q[ADDR_WIDTH-1:2], 2'b00};

  // Byte enables and replicated store data from latched size/address.
  always_comb begin
    dm_be    = 4'b1111;
    dm_wdata = 32'h0;
    case (size_q)
      2'b00: begin
        dm_be    = 4'b0001 << addr_q[1:0];
        dm_wdata = {4{vt_q[7:0]}};
      end
      2'b01: begin
        dm_be    = addr_q[1] ? 4'b1100 : 4'b0011;
        dm_wdata = {2{vt_q[15:0]}};
      end
      default: begin
        dm_be    = 4'b1111;
        dm_wdata = vt_q;
      end
    endcase
    if (!is_store_q) dm_wdata = 32'h0;
  end

  // Load lane extraction and sign/zero extension.
  always_comb begin
    case (addr_q[1:0])
      2'b00:   ld_byte = dm_rdata[7:0];
      2'b01:   ld_byte = dm_rdata[15:8];
      2'b10:   ld_byte = dm_rdata[23:16];
      default: ld_byte = dm_rdata[31:24];
    endcase
    ld_half = addr_q[1] ? dm_rdata[31:16] : dm_rdata[15:0];
    case (size_q)
      2'b00:   ld_data = {{24{ld_byte[7] & ~uns_q}}, ld_byte};
      2'b01:   ld_data = {{16{ld_half[15] & ~uns_q}}, ld_half};
      default: ld_data = dm_rdata;
    endcase
  end

  // Next-state and next-data logic for the stage FSM.
  always_comb begin
    // NOTE: every *_d gets a default first so no path leaves it unassigned,
    // which would otherwise infer a latch.
    state_d     = state_q;
    rd_d        = rd_q;
    addr_d      = addr_q;
    vt_d        = vt_q;
    is_store_d  = is_store_q;
    size_d      = size_q;
    uns_d       = uns_q;
    reg_write_d = reg_write_q;
    result_d    = result_q;
    out_regw_d  = out_regw_q;
    exc_d       = exc_q;

    case (state_q)
      S_REQ: begin
        if (dm_gnt) begin
          if (is_store_q) begin
            state_d    = S_OUT;
            out_regw_d = 1'b0;
          end else begin
            state_d = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        if (dm_rvalid) begin
          state_d    = S_OUT;
          result_d   = ld_data;
          out_regw_d = reg_write_q;
        end
      end
      S_OUT: begin
        if (out_ready && !in_valid) state_d = S_IDLE;
      end
      default: ;
    endcase

    // A new instruction overrides whatever the case above decided.
    if (accept) begin
      rd_d        = in_rd;
      addr_d      = in_out;
      vt_d        = in_vt;
      is_store_d  = in_mem_write;
      size_d      = in_size;
      uns_d       = in_unsigned;
      reg_write_d = in_reg_write;
      result_d    = in_out;
      exc_d       = 1'b0;
      if (misaligned) begin
        state_d    = S_OUT;
        exc_d      = 1'b1;
        out_regw_d = 1'b0;
      end else if (in_mem_read || in_mem_write) begin
        state_d    = S_REQ;
        out_regw_d = 1'b0;
      end else begin
        state_d    = S_OUT;
        out_regw_d = in_reg_write;
      end
    end
  end

  // State and datapath registers; everything clears on reset.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q     <= S_IDLE;
      rd_q        <= '0;
      addr_q      <= '0;
      vt_q        <= '0;
      is_store_q  <= 1'b0;
      size_q      <= '0;
      uns_q       <= 1'b0;
      reg_write_q <= 1'b0;
      result_q    <= '0;
      out_regw_q  <= 1'b0;
      exc_q       <= 1'b0;
    end else begin
      // NOTE: non-blocking so all registers update together from the
      // pre-edge values, independent of statement order.
      state_q     <= state_d;
      rd_q        <= rd_d;
      addr_q      <= addr_d;
      vt_q        <= vt_d;
      is_store_q  <= is_store_d;
      size_q      <= size_d;
      uns_q       <= uns_d;
      reg_write_q <= reg_write_d;
      result_q    <= result_d;
      out_regw_q  <= out_regw_d;
      exc_q       <= exc_d;
    end
  end

  assign out_valid     = (state_q == S_OUT);
  assign out_rd        = rd_q;
  assign out_result    = result_q;
  assign out_reg_write = out_valid & out_regw_q;
`ifdef MEM_MISALIGN_TRAP_EN
  assign out_exc       = out_valid & exc_q;
`endif

  // The latched exception flag is unused when the trap feature is off.
  logic unused_exc;
  assign unused_exc = exc_q;

endmodule

// File: tb/tb_memory_stage.sv
// tb_memory_stage: directed-vector bench for memory_stage.
// Inputs are driven on the falling edge; outputs are checked 1ns later,
// well away from the rising (active) edge.
module tb_memory_stage;

  logic        clk = 1'b0;
  logic        resetn;
  logic        in_valid;
  logic        in_ready;
  logic [4:0]  in_rd;
  logic [31:0] in_out;
  logic [31:0] in_vt;
  logic        in_mem_read;
  logic        in_mem_write;
  logic [1:0]  in_size;
  logic        in_unsigned;
  logic        in_reg_write;
  logic        dm_req;
  logic        dm_we;
  logic [31:0] dm_addr;
  logic [3:0]  dm_be;
  logic [31:0] dm_wdata;
  logic        dm_gnt;
  logic        dm_rvalid;
  logic [31:0] dm_rdata;
  logic        out_valid;
  logic        out_ready;
  logic [4:0]  out_rd;
  logic [31:0] out_result;
  logic        out_reg_write;
`ifdef MEM_MISALIGN_TRAP_EN
  logic        out_exc;
`endif

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  memory_stage #(.ADDR_WIDTH(32)) dut (
    .clk          (clk),
    .resetn       (resetn),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_rd        (in_rd),
    .in_out       (in_out),
    .in_vt        (in_vt),
    .in_mem_read  (in_mem_read),
    .in_mem_write (in_mem_write),
    .in_size      (in_size),
    .in_unsigned  (in_unsigned),
    .in_reg_write (in_reg_write),
    .dm_req       (dm_req),
    .dm_we        (dm_we),
    .dm_addr      (dm_addr),
    .dm_be        (dm_be),
    .dm_wdata     (dm_wdata),
    .dm_gnt       (dm_gnt),
    .dm_rvalid    (dm_rvalid),
    .dm_rdata     (dm_rdata),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_rd       (out_rd),
    .out_result   (out_result),
`ifdef MEM_MISALIGN_TRAP_EN
    .out_exc      (out_exc),
`endif
    .out_reg_write(out_reg_write)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic set_op(input logic [4:0] rd, input logic [31:0] out, input logic [31:0] vt,
                        input logic rd_m, input logic wr_m, input logic [1:0] sz,
                        input logic uns, input logic regw);
    in_valid     = 1'b1;
    in_rd        = rd;
    in_out       = out;
    in_vt        = vt;
    in_mem_read  = rd_m;
    in_mem_write = wr_m;
    in_size      = sz;
    in_unsigned  = uns;
    in_reg_write = regw;
  endtask

  // Load: gnt arrives gnt_dly cycles into REQ, rvalid rv_dly cycles after gnt.
  task automatic do_load(input string tag, input logic [31:0] addr, input logic [1:0] sz,
                         input logic uns, input logic [31:0] rdata, input int gnt_dly,
                         input int rv_dly, input logic [31:0] exp_addr,
                         input logic [3:0] exp_be, input logic [31:0] exp_res);
    @(negedge clk);
    set_op(5'd9, addr, 32'hFFFF_FFFF, 1'b1, 1'b0, sz, uns, 1'b1);
    #1 check({tag, "_accept"}, 32'(in_ready), 32'd1);
    for (int i = 0; i <= gnt_dly; i++) begin
      @(negedge clk);
      in_valid = 1'b0;
      dm_gnt   = (i == gnt_dly);
      #1;
      check({tag, "_req"}, 32'(dm_req), 32'd1);
      check({tag, "_busy"}, 32'(in_ready), 32'd0);
      if (i == 0) begin
        check({tag, "_we"}, 32'(dm_we), 32'd0);
        check({tag, "_addr"}, dm_addr, exp_addr);
        check({tag, "_be"}, 32'(dm_be), 32'(exp_be));
        check({tag, "_wdata"}, dm_wdata, 32'd0);
      end
    end
    for (int j = 1; j <= rv_dly; j++) begin
      @(negedge clk);
      dm_gnt    = 1'b0;
      dm_rvalid = (j == rv_dly);
      dm_rdata  = rdata;
      #1;
      check({tag, "_req_drop"}, 32'(dm_req), 32'd0);
      check({tag, "_wait_busy"}, 32'(in_ready), 32'd0);
    end
    @(negedge clk);
    dm_rvalid = 1'b0;
    dm_rdata  = 32'h0;
    #1;
    check({tag, "_valid"}, 32'(out_valid), 32'd1);
    check({tag, "_result"}, out_result, exp_res);
    check({tag, "_regw"}, 32'(out_reg_write), 32'd1);
    check({tag, "_rd"}, 32'(out_rd), 32'd9);
  endtask

  task automatic do_store(input string tag, input logic [31:0] addr, input logic [1:0] sz,
                          input logic [31:0] vt, input int gnt_dly,
                          input logic [31:0] exp_addr, input logic [3:0] exp_be,
                          input logic [31:0] exp_wdata);
    @(negedge clk);
    set_op(5'd3, addr, vt, 1'b0, 1'b1, sz, 1'b0, 1'b0);
    #1 check({tag, "_accept"}, 32'(in_ready), 32'd1);
    for (int i = 0; i <= gnt_dly; i++) begin
      @(negedge clk);
      in_valid = 1'b0;
      dm_gnt   = (i == gnt_dly);
      #1;
      check({tag, "_req"}, 32'(dm_req), 32'd1);
      check({tag, "_we"}, 32'(dm_we), 32'd1);
      check({tag, "_addr"}, dm_addr, exp_addr);
      check({tag, "_be"}, 32'(dm_be), 32'(exp_be));
      check({tag, "_wdata"}, dm_wdata, exp_wdata);
    end
    @(negedge clk);
    dm_gnt = 1'b0;
    #1;
    check({tag, "_valid"}, 32'(out_valid), 32'd1);
    check({tag, "_regw"}, 32'(out_reg_write), 32'd0);
    check({tag, "_req_drop"}, 32'(dm_req), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    resetn       = 1'b0;
    in_valid     = 1'b0;
    in_rd        = '0;
    in_out       = '0;
    in_vt        = '0;
    in_mem_read  = 1'b0;
    in_mem_write = 1'b0;
    in_size      = '0;
    in_unsigned  = 1'b0;
    in_reg_write = 1'b0;
    dm_gnt       = 1'b0;
    dm_rvalid    = 1'b0;
    dm_rdata     = '0;
    out_ready    = 1'b1;

    // Reset state
    repeat (2) @(negedge clk);
    #1;
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_dm_req", 32'(dm_req), 32'd0);
    check("rst_dm_we", 32'(dm_we), 32'd0);
    check("rst_regw", 32'(out_reg_write), 32'd0);
    check("rst_result", out_result, 32'd0);
    @(negedge clk);
    resetn = 1'b1;

    // ALU op: one cycle to out_valid
    @(negedge clk);
    set_op(5'd5, 32'h0000_1234, 32'h0, 1'b0, 1'b0, 2'b10, 1'b0, 1'b1);
    #1 check("alu_accept", 32'(in_ready), 32'd1);
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    check("alu_valid", 32'(out_valid), 32'd1);
    check("alu_result", out_result, 32'h0000_1234);
    check("alu_regw", 32'(out_reg_write), 32'd1);
    check("alu_rd", 32'(out_rd), 32'd5);
    check("alu_no_req", 32'(dm_req), 32'd0);
    @(negedge clk);
    #1 check("alu_idle", 32'(out_valid), 32'd0);

    // Stray rvalid/gnt while idle must be ignored
    dm_rvalid = 1'b1;
    dm_gnt    = 1'b1;
    @(negedge clk);
    dm_rvalid = 1'b0;
    dm_gnt    = 1'b0;
    #1;
    check("stray_valid", 32'(out_valid), 32'd0);
    check("stray_req", 32'(dm_req), 32'd0);

    // Stores
    do_store("sb", 32'h0000_0103, 2'b00, 32'h0000_00AB, 0, 32'h0000_0100, 4'b1000, 32'hABAB_ABAB);
    do_store("sh", 32'h0000_0006, 2'b01, 32'h1234_ABCD, 1, 32'h0000_0004, 4'b1100, 32'hABCD_ABCD);
    do_store("sw", 32'h0000_0200, 2'b10, 32'hDEAD_BEEF, 0, 32'h0000_0200, 4'b1111, 32'hDEAD_BEEF);

    // Loads
    do_load("lb", 32'h0000_0102, 2'b00, 1'b0, 32'h0080_FF00, 0, 1,
            32'h0000_0100, 4'b0100, 32'hFFFF_FF80);
    do_load("lbu", 32'h0000_0102, 2'b00, 1'b1, 32'h0080_FF00, 0, 1,
            32'h0000_0100, 4'b0100, 32'h0000_0080);
    do_load("lh", 32'h0000_0002, 2'b01, 1'b0, 32'h8001_1234, 3, 2,
            32'h0000_0000, 4'b1100, 32'hFFFF_8001);
    do_load("lhu", 32'h0000_0010, 2'b01, 1'b1, 32'h1111_F00D, 0, 1,
            32'h0000_0010, 4'b0011, 32'h0000_F00D);
    do_load("lw_sz11", 32'h0000_0020, 2'b11, 1'b0, 32'hCAFE_BABE, 1, 1,
            32'h0000_0020, 4'b1111, 32'hCAFE_BABE);

    // Backpressure in OUT, then back-to-back accept
    @(negedge clk);
    out_ready = 1'b0;
    set_op(5'd7, 32'h0000_0055, 32'h0, 1'b0, 1'b0, 2'b10, 1'b0, 1'b1);
    @(negedge clk);
    in_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      #1;
      check("bp_valid", 32'(out_valid), 32'd1);
      check("bp_result", out_result, 32'h0000_0055);
      check("bp_rd", 32'(out_rd), 32'd7);
      check("bp_in_ready", 32'(in_ready), 32'd0);
      @(negedge clk);
    end
    out_ready = 1'b1;
    set_op(5'd8, 32'h0000_0066, 32'h0, 1'b0, 1'b0, 2'b10, 1'b0, 1'b1);
    #1 check("b2b_in_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    check("b2b_valid", 32'(out_valid), 32'd1);
    check("b2b_result", out_result, 32'h0000_0066);
    check("b2b_rd", 32'(out_rd), 32'd8);

    // Misaligned word at 0x6
`ifdef MEM_MISALIGN_TRAP_EN
    @(negedge clk);
    set_op(5'd4, 32'h0000_0006, 32'h0, 1'b1, 1'b0, 2'b10, 1'b0, 1'b1);
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    check("trap_valid", 32'(out_valid), 32'd1);
    check("trap_exc", 32'(out_exc), 32'd1);
    check("trap_result", out_result, 32'h0000_0006);
    check("trap_regw", 32'(out_reg_write), 32'd0);
    check("trap_no_req", 32'(dm_req), 32'd0);
`else
    do_load("lw_mis", 32'h0000_0006, 2'b10, 1'b0, 32'h1357_9BDF, 0, 1,
            32'h0000_0004, 4'b1111, 32'h1357_9BDF);
`endif

    // Reset in the middle of a request: dm_req must drop immediately
    @(negedge clk);
    set_op(5'd2, 32'h0000_0040, 32'h0, 1'b1, 1'b0, 2'b10, 1'b0, 1'b1);
    @(negedge clk);
    in_valid = 1'b0;
    #1 check("mid_req", 32'(dm_req), 32'd1);
    #1 resetn = 1'b0;
    #1;
    check("mid_req_drop", 32'(dm_req), 32'd0);
    check("mid_in_ready", 32'(in_ready), 32'd1);
    check("mid_out_valid", 32'(out_valid), 32'd0);
    @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);
    #1 check("post_rst_req", 32'(dm_req), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
